// File: rtl/change_dispenser_if.sv
// Bus between the vending controller/hopper side and the change dispenser:
// payout request, refill, per-coin hopper handshake and status/stock reporting.
interface change_dispenser_if;
  logic       start;
  logic [7:0] amount;
  logic       refill;
  logic       hopper_ack;
  logic [2:0] coin_out;
  logic       busy;
  logic       done;
  logic       fault;
  logic [7:0] remaining;
  logic [7:0] paid_total;
  logic [7:0] stock5;
  logic [7:0] stock2;
  logic [7:0] stock1;

  modport master (
    output start, amount, refill, hopper_ack,
    input  coin_out, busy, done, fault, remaining, paid_total,
           stock5, stock2, stock1
  );

  modport slave (
    input  start, amount, refill, hopper_ack,
    output coin_out, busy, done, fault, remaining, paid_total,
           stock5, stock2, stock1
  );
endinterface

// File: rtl/change_dispenser.sv
// Change dispenser: pays a requested amount out of three coin tubes
// (5/2/1 zl), largest coin first, one eject pulse + hopper acknowledge per
// coin. Tracks per-tube stock and flags shortfall or hopper timeout.
module change_dispenser #(
  parameter int PULSE_CYCLES = 4,
  parameter int ACK_TIMEOUT  = 1000,
  parameter int INIT_STOCK   = 20
) (
  input logic                clk,
  input logic                reset,
  change_dispenser_if.slave  bus
);

  localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam int TW = (ACK_TIMEOUT  > 1) ? $clog2(ACK_TIMEOUT)  : 1;
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] ACK_LAST   = TW'(ACK_TIMEOUT - 1);
  localparam logic [7:0]    STOCK_FULL = 8'(INIT_STOCK);

  typedef enum logic [2:0] {
    IDLE, SELECT, PULSE, WAIT_ACK, FINISH, FAULT
  } state_t;

  state_t        state;
  logic [2:0]    coin_sel;
  logic [PW-1:0] pulse_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [2:0]    coin_out;
  logic          busy;
  logic          done;
  logic          fault;
  logic [7:0]    remaining;
  logic [7:0]    paid_total;
  logic [7:0]    stock5;
  logic [7:0]    stock2;
  logic [7:0]    stock1;

  // Greedy choice: largest coin that still fits the owed amount and is in
  // stock; all-zero means nothing can be paid (shortfall).
  function automatic logic [2:0] pick_coin(input logic [7:0] rem,
                                           input logic [7:0] s5,
                                           input logic [7:0] s2,
                                           input logic [7:0] s1);
    if (rem >= 8'd5 && s5 != 8'd0)      return 3'b100;
    else if (rem >= 8'd2 && s2 != 8'd0) return 3'b010;
    else if (rem >= 8'd1 && s1 != 8'd0) return 3'b001;
    else                                return 3'b000;
  endfunction

  // Face value in zl of a one-hot coin select.
  function automatic logic [7:0] coin_value(input logic [2:0] sel);
    case (sel)
      3'b100:  return 8'd5;
      3'b010:  return 8'd2;
      default: return 8'd1;
    endcase
  endfunction

  logic [2:0] next_coin;
  assign next_coin = pick_coin(remaining, stock5, stock2, stock1);

  // Payout FSM with all outputs and stock counters registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      coin_sel   <= 3'b000;
      pulse_cnt  <= '0;
      tmo_cnt    <= '0;
      coin_out   <= 3'b000;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
      remaining  <= 8'd0;
      paid_total <= 8'd0;
      stock5     <= STOCK_FULL;
      stock2     <= STOCK_FULL;
      stock1     <= STOCK_FULL;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.refill) begin
            stock5 <= STOCK_FULL;
            stock2 <= STOCK_FULL;
            stock1 <= STOCK_FULL;
          end
          if (bus.start) begin
            remaining  <= bus.amount;
            paid_total <= 8'd0;
            fault      <= 1'b0;
            busy       <= 1'b1;
            state      <= SELECT;
          end
        end
        SELECT: begin
          if (remaining == 8'd0) begin
            done  <= 1'b1;
            state <= FINISH;
          end else if (next_coin != 3'b000) begin
            coin_sel  <= next_coin;
            coin_out  <= next_coin;
            pulse_cnt <= '0;
            state     <= PULSE;
          end else begin
            fault <= 1'b1;
            done  <= 1'b1;
            state <= FAULT;
          end
        end
        PULSE: begin
          if (pulse_cnt == PULSE_LAST) begin
            coin_out <= 3'b000;
            tmo_cnt  <= '0;
            state    <= WAIT_ACK;
          end else begin
            pulse_cnt <= pulse_cnt + 1'b1;
          end
        end
        WAIT_ACK: begin
          if (bus.hopper_ack) begin
            remaining  <= remaining - coin_value(coin_sel);
            paid_total <= paid_total + coin_value(coin_sel);
            case (coin_sel)
              3'b100:  stock5 <= stock5 - 8'd1;
              3'b010:  stock2 <= stock2 - 8'd1;
              default: stock1 <= stock1 - 8'd1;
            endcase
            tmo_cnt <= '0;
            state   <= SELECT;
          end else if (tmo_cnt == ACK_LAST) begin
            tmo_cnt <= '0;
            fault   <= 1'b1;
            done    <= 1'b1;
            state   <= FAULT;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        FINISH, FAULT: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          coin_out <= 3'b000;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.coin_out   = coin_out;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.fault      = fault;
  assign bus.remaining  = remaining;
  assign bus.paid_total = paid_total;
  assign bus.stock5     = stock5;
  assign bus.stock2     = stock2;
  assign bus.stock1     = stock1;

endmodule
